lp_buffer_pingpong_rd: RTL and testbench

Two-bank ping-pong frame buffer. An upstream writer fills one bank with a fixed-length frame while a downstream reader drains the other bank on request. The block is the read-side counterpart to the per-write-cycle delay buffers in the beam-index path. It converts sparse, gapped frame writes into contiguous, request-driven bursts that carry sop/eop framing.

---
 rtl/lp_buffer_pingpong_rd.sv | 174 +++++++++++++++++
 tb/tb_lp_buffer_pingpong_rd.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lp_buffer_pingpong_rd.sv
// Two-bank ping-pong frame buffer: gapped fixed-length frame writes fill one bank
// while the other bank is drained on request as a contiguous sop/eop burst.
module lp_buffer_pingpong_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_vld,
    input  logic                  i_wr_sop,
    input  logic                  i_rd_req,
    output logic                  o_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_vld,
    output logic                  o_rd_sop,
    output logic                  o_rd_eop,
    output logic [1:0]            o_frm_cnt,
    output logic                  o_wr_ovf,
    output logic                  o_wr_err,
    output logic                  o_rd_err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FL_C  = CW'(FRAME_LEN);
    localparam logic [CW-1:0] FL_M1 = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_PEND, RD_RUN} rd_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    rd_state_t   rd_state_q, rd_state_d;
    logic        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_ptr_q, rd_ptr_d;

    logic                  ready;
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   wr_addr;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH:0]   ram_rd_addr;
    logic                  ovf_d, werr_d, rerr_d, vld_d, sop_d, eop_d;
    logic [1:0]            frm_cnt_d;

    logic [DATA_WIDTH-1:0] mem [0:2*(2**ADDR_WIDTH)-1];

    assign ready       = (rd_state_q == RD_IDLE) && (bank_q[0] == B_FULL || bank_q[1] == B_FULL);
    assign o_rd_ready  = ready;
    assign ram_rd_addr = {rd_bank_q, rd_ptr_q[ADDR_WIDTH-1:0]};

    always_comb begin
        bank_d[0]  = bank_q[0];
        bank_d[1]  = bank_q[1];
        rd_state_d = rd_state_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_en      = 1'b0;
        wr_addr    = {wr_bank_q, wr_cnt_q[ADDR_WIDTH-1:0]};
        ram_rd_en  = 1'b0;
        ovf_d      = 1'b0;
        werr_d     = 1'b0;
        rerr_d     = i_rd_req && !ready;
        vld_d      = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;

        // Write side only ever touches bank[wr_bank]; a sop needs EMPTY already registered.
        if (i_wr_vld && i_wr_sop) begin
            if (bank_q[wr_bank_q] == B_EMPTY || bank_q[wr_bank_q] == B_FILLING) begin
                werr_d            = (bank_q[wr_bank_q] == B_FILLING);
                bank_d[wr_bank_q] = B_FILLING;
                wr_en             = 1'b1;
                wr_addr           = {wr_bank_q, {ADDR_WIDTH{1'b0}}};
                wr_cnt_d          = CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (i_wr_vld && bank_q[wr_bank_q] == B_FILLING) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (wr_cnt_q == FL_M1) begin
                bank_d[wr_bank_q] = B_FULL;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Read side only touches bank[rd_bank], which the write side never sees as EMPTY/FILLING here.
        case (rd_state_q)
            RD_IDLE: begin
                if (i_rd_req && ready) begin
                    bank_d[rd_bank_q] = B_DRAINING;
                    rd_ptr_d          = '0;
                    rd_state_d        = RD_PEND;
                end
            end
            RD_PEND: begin
                ram_rd_en  = 1'b1;
                vld_d      = 1'b1;
                sop_d      = 1'b1;
                rd_ptr_d   = CW'(1);
                rd_state_d = RD_RUN;
            end
            RD_RUN: begin
                if (rd_ptr_q == FL_C) begin
                    bank_d[rd_bank_q] = B_EMPTY;
                    rd_bank_d         = ~rd_bank_q;
                    rd_state_d        = RD_IDLE;
                end else begin
                    ram_rd_en = 1'b1;
                    vld_d     = 1'b1;
                    eop_d     = (rd_ptr_q == FL_M1);
                    rd_ptr_d  = rd_ptr_q + CW'(1);
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        frm_cnt_d = 2'(bank_d[0] == B_FULL) + 2'(bank_d[1] == B_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bank_q[0]  <= B_EMPTY;
            bank_q[1]  <= B_EMPTY;
            rd_state_q <= RD_IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            rd_state_q <= rd_state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_vld  <= 1'b0;
            o_rd_sop  <= 1'b0;
            o_rd_eop  <= 1'b0;
            o_frm_cnt <= 2'd0;
            o_wr_ovf  <= 1'b0;
            o_wr_err  <= 1'b0;
            o_rd_err  <= 1'b0;
            o_rd_data <= '0;
        end else begin
            o_rd_vld  <= vld_d;
            o_rd_sop  <= sop_d;
            o_rd_eop  <= eop_d;
            o_frm_cnt <= frm_cnt_d;
            o_wr_ovf  <= ovf_d;
            o_wr_err  <= werr_d;
            o_rd_err  <= rerr_d;
            if (ram_rd_en) begin
                o_rd_data <= mem[ram_rd_addr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_lp_buffer_pingpong_rd.sv
// Bench for lp_buffer_pingpong_rd with FRAME_LEN=4: a per-cycle vector table for a
// single gapped frame, then directed sequences for ping-pong order, overflow, restart and reset.
module tb_lp_buffer_pingpong_rd;

    localparam int DW = 16;
    localparam int FL = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] wr_data;
    logic          wr_vld, wr_sop, rd_req;
    logic          rd_ready, rd_vld, rd_sop, rd_eop;
    logic [DW-1:0] rd_data;
    logic [1:0]    frm_cnt;
    logic          wr_ovf, wr_err, rd_err;

    lp_buffer_pingpong_rd #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_reset(reset), .i_wr_data(wr_data), .i_wr_vld(wr_vld),
        .i_wr_sop(wr_sop), .i_rd_req(rd_req), .o_rd_ready(rd_ready), .o_rd_data(rd_data),
        .o_rd_vld(rd_vld), .o_rd_sop(rd_sop), .o_rd_eop(rd_eop), .o_frm_cnt(frm_cnt),
        .o_wr_ovf(wr_ovf), .o_wr_err(wr_err), .o_rd_err(rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld, sop, req;
        logic [DW-1:0] data;
        logic          e_vld, e_sop, e_eop, e_rdy;
        logic [DW-1:0] e_data;
        logic [1:0]    e_cnt;
        logic [2:0]    e_flags;
    } vec_t;

    vec_t          vecs[$];
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] got_q[$];
    int            sop_cyc[$];
    int            eop_cyc[$];
    int tests = 0, fails = 0;
    int cyc_n = 0, ovf_n = 0, werr_n = 0, rerr_n = 0, eop_n = 0;

    function automatic vec_t mk(input logic vld, sop, input logic [DW-1:0] d, input logic req,
                                input logic ev, es, ee, input logic [DW-1:0] ed,
                                input logic [1:0] ec, input logic er, input logic [2:0] ef);
        vec_t v;
        v.vld = vld; v.sop = sop; v.data = d; v.req = req;
        v.e_vld = ev; v.e_sop = es; v.e_eop = ee; v.e_data = ed;
        v.e_cnt = ec; v.e_rdy = er; v.e_flags = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // One clock: drive at negedge, sample the post-edge outputs at the next negedge.
    task automatic cyc(input logic vld, input logic sop, input logic [DW-1:0] d, input logic req);
        wr_vld = vld; wr_sop = sop; wr_data = d; rd_req = req;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (rd_vld) begin
            got_q.push_back({rd_sop, rd_eop, rd_data});
            if (rd_sop) sop_cyc.push_back(cyc_n);
            if (rd_eop) eop_cyc.push_back(cyc_n);
        end
        if (rd_eop) eop_n++;
        if (wr_ovf) ovf_n++;
        if (wr_err) werr_n++;
        if (rd_err) rerr_n++;
        wr_vld = 1'b0; wr_sop = 1'b0; wr_data = '0; rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic write_frame(input int base);
        for (int k = 0; k < FL; k++) cyc(1'b1, k == 0, DW'(base + k), 1'b0);
    endtask

    task automatic exp_frame(input int base);
        for (int k = 0; k < FL; k++) exp_q.push_back({k == 0, k == FL - 1, DW'(base + k)});
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 50 && !rd_ready; i++) idle(1);
        check(name, rd_ready, 1);
    endtask

    task automatic read_req(input string name);
        wait_ready(name);
        cyc(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic compare_got(input string name);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
        got_q.delete(); exp_q.delete(); sop_cyc.delete(); eop_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_vld = 1'b0; wr_sop = 1'b0; wr_data = '0; rd_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ovf_n = 0; werr_n = 0; rerr_n = 0; eop_n = 0;
        got_q.delete(); exp_q.delete(); sop_cyc.delete(); eop_cyc.delete();
    endtask

    initial begin
        reset = 1'b1; wr_vld = 1'b0; wr_sop = 1'b0; wr_data = '0; rd_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {rd_ready, rd_vld, rd_sop, rd_eop, rd_data, frm_cnt, wr_ovf, wr_err, rd_err}, 0);
        reset = 1'b0;

        // Gapped single frame 1..4, then a drain, then a request with nothing buffered.
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 1, 1, 3'b000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 4, 0, 0, 3'b001));
        foreach (vecs[i]) begin
            cyc(vecs[i].vld, vecs[i].sop, vecs[i].data, vecs[i].req);
            check($sformatf("vec%0d", i),
                  {rd_vld, rd_sop, rd_eop, rd_data, frm_cnt, rd_ready, wr_ovf, wr_err, rd_err},
                  {vecs[i].e_vld, vecs[i].e_sop, vecs[i].e_eop, vecs[i].e_data,
                   vecs[i].e_cnt, vecs[i].e_rdy, vecs[i].e_flags});
        end
        got_q.delete(); sop_cyc.delete(); eop_cyc.delete();

        // Two frames back to back, drained in order with the minimum gap.
        do_reset();
        write_frame(10);
        write_frame(20);
        idle(1);
        check("ab_cnt2", frm_cnt, 2);
        read_req("ab_rdy_a");
        check("ab_cnt1", frm_cnt, 1);
        read_req("ab_rdy_b");
        check("ab_cnt0", frm_cnt, 0);
        idle(FL + 3);
        check("ab_gap", (sop_cyc.size() == 2 && eop_cyc.size() == 2) ? sop_cyc[1] - eop_cyc[0] : -1, 3);
        exp_frame(10);
        exp_frame(20);
        compare_got("ab");

        // Third frame with both banks full is dropped.
        do_reset();
        write_frame(30);
        write_frame(40);
        write_frame(50);
        idle(1);
        check("ovf_pulses", ovf_n, 1);
        check("ovf_cnt2", frm_cnt, 2);
        read_req("ovf_rdy_a");
        read_req("ovf_rdy_b");
        idle(FL + 3);
        exp_frame(30);
        exp_frame(40);
        compare_got("ovf");

        // Mid-frame sop restarts the frame.
        do_reset();
        cyc(1'b1, 1'b1, 16'd1, 1'b0);
        cyc(1'b1, 1'b0, 16'd2, 1'b0);
        write_frame(5);
        idle(1);
        check("werr_pulses", werr_n, 1);
        check("werr_cnt1", frm_cnt, 1);
        read_req("werr_rdy");
        idle(FL + 3);
        exp_frame(5);
        compare_got("werr");

        // Rejected requests: nothing buffered, and during a burst.
        do_reset();
        cyc(1'b0, 1'b0, '0, 1'b1);
        write_frame(60);
        read_req("rerr_rdy");
        idle(2);
        cyc(1'b0, 1'b0, '0, 1'b1);
        idle(FL + 4);
        check("rerr_pulses", rerr_n, 2);
        exp_frame(60);
        compare_got("rerr");

        // Reset in the middle of a burst aborts it.
        do_reset();
        write_frame(70);
        read_req("rst_rdy");
        idle(3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {rd_vld, rd_eop, frm_cnt, rd_ready}, 0);
        reset = 1'b0;
        idle(3);
        check("rst_no_eop", eop_n, 0);
        check("rst_words_before", got_q.size(), 3);
        got_q.delete(); sop_cyc.delete(); eop_cyc.delete();
        write_frame(80);
        read_req("rst_rdy2");
        idle(FL + 3);
        exp_frame(80);
        compare_got("rst_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
